// File: rtl/fb_pkg.sv
// fb_pkg: shared timing constants, vertical sequencer state type and the
// source-dimension clamp helper used by the framebuffer scan controller.
package fb_pkg;

  localparam int WIDTH    = 320;
  localparam int HEIGHT   = 240;
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int H_TOTAL  = 1650;
  localparam int V_TOTAL  = 750;
  localparam int SPAN     = 960;
  localparam int XSTART   = (H_ACTIVE - SPAN) / 2;
  localparam int XSTOP    = (H_ACTIVE + SPAN) / 2;
  localparam int AW       = $clog2(WIDTH * HEIGHT);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VACT   = 2'd1,
    VBLANK = 2'd2
  } vstate_t;

  // Clamp a requested dimension to [1,hi]; a zero request is treated as 1.
  function automatic logic [9:0] clamp_dim(input logic [10:0] v, input logic [9:0] hi);
    logic [9:0] r;
    if (v == 11'd0) begin
      r = 10'd1;
    end else if (v > {1'b0, hi}) begin
      r = hi;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_dda_step.sv
// fb_dda_step: one axis of the fractional (DDA) upscaler.
// Each step adds i_inc to a 12-bit accumulator; when it reaches MOD the
// accumulator wraps and the index advances, saturating at i_inc-1.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_clr          : clear accumulator and index (wins over i_step)
//   i_step         : advance the accumulator this cycle
//   i_inc          : effective source size (1..MOD)
//   o_idx          : current source index
//   o_adv          : index increments at the coming edge (not when saturated)
module fb_dda_step #(
  parameter int MOD = 960,
  parameter int IW  = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_step,
  input  logic [IW-1:0] i_inc,
  output logic [IW-1:0] o_idx,
  output logic          o_adv
);

  logic [11:0]   r_acc;
  logic [IW-1:0] r_idx;
  logic [11:0]   w_acc_n;
  logic          w_wrap;
  logic          w_sat;

  // Next accumulator value, wrap detect and saturation detect.
  always_comb begin
    w_acc_n = r_acc + {{(12-IW){1'b0}}, i_inc};
    w_wrap  = (w_acc_n >= 12'(MOD));
    w_sat   = (r_idx >= (i_inc - IW'(1)));
    o_adv   = i_step & w_wrap & ~w_sat;
  end

  assign o_idx = r_idx;

  // Accumulator and saturating index registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= 12'd0;
      r_idx <= '0;
    end else if (i_clr) begin
      r_acc <= 12'd0;
      r_idx <= '0;
    end else if (i_step) begin
      if (w_wrap) begin
        r_acc <= w_acc_n - 12'(MOD);
        if (!w_sat) begin
          r_idx <= r_idx + IW'(1);
        end
      end else begin
        r_acc <= w_acc_n;
      end
    end
  end

endmodule

// File: rtl/fb_scan_ctrl.sv
// fb_scan_ctrl: read-side scan sequencer for the BRAM framebuffer (clk_pixel domain).
// Maps HDMI timing counters onto framebuffer addresses with DDA upscaling into a
// centred SPAN-wide window, and flags which pixels carry image data vs border.
// Source geometry is latched at frame end so mid-frame changes never tear.
// Ports:
//   i_clk_pixel, i_reset     : pixel clock, synchronous active-high reset
//   i_cx, i_cy               : HDMI column/row counters
//   i_src_width/height       : source size (1..WIDTH / 1..HEIGHT)
//   i_overlay                : 1 selects fixed 256x224 geometry
//   o_rd_en, o_rd_addr       : framebuffer read strobe and address
//   o_vid_active             : read data arriving this cycle is image data
//   o_overlay_x/y            : source coordinate of that data (truncated)
//   o_frame_start            : one-cycle pulse after geometry is latched
module fb_scan_ctrl
  import fb_pkg::*;
(
  input  logic          i_clk_pixel,
  input  logic          i_reset,
  input  logic [10:0]   i_cx,
  input  logic [9:0]    i_cy,
  input  logic [10:0]   i_src_width,
  input  logic [9:0]    i_src_height,
  input  logic          i_overlay,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_vid_active,
  output logic [7:0]    o_overlay_x,
  output logic [7:0]    o_overlay_y,
  output logic          o_frame_start
);

  vstate_t       r_vstate;
  logic [9:0]    r_eff_w;
  logic [9:0]    r_eff_h;
  logic [AW-1:0] r_line_base;
  logic [7:0]    r_cur_x;
  logic [7:0]    r_cur_y;

  logic          w_fe;
  logic          w_line_end;
  logic          w_in_hw;
  logic [9:0]    w_xx;
  logic [9:0]    w_yy;
  logic          w_y_adv;
  logic          w_x_adv_unused;
  logic [1:0]    w_yy_hi_unused;
  logic [9:0]    w_req_w;
  logic [9:0]    w_req_h;

  // Frame end, line end and the read window (one cycle ahead of XSTART for BRAM latency).
  always_comb begin
    w_fe       = (i_cx == 11'(H_TOTAL - 1)) && (i_cy == 10'(V_TOTAL - 1));
    w_line_end = (r_vstate == VACT) && (i_cx == 11'(XSTOP - 1));
    w_in_hw    = (r_vstate == VACT) && (i_cx >= 11'(XSTART - 1)) && (i_cx < 11'(XSTOP - 1));
    w_req_w    = clamp_dim(i_overlay ? 11'd256 : i_src_width, 10'(SPAN));
    w_req_h    = clamp_dim(i_overlay ? 11'd224 : {1'b0, i_src_height}, 10'(V_ACTIVE));
  end

  assign w_yy_hi_unused = w_yy[9:8];

  fb_dda_step #(.MOD(SPAN), .IW(10)) u_dda_x (
    .i_clk   (i_clk_pixel),
    .i_reset (i_reset),
    .i_clr   (w_fe | w_line_end),
    .i_step  (w_in_hw),
    .i_inc   (r_eff_w),
    .o_idx   (w_xx),
    .o_adv   (w_x_adv_unused)
  );

  fb_dda_step #(.MOD(V_ACTIVE), .IW(10)) u_dda_y (
    .i_clk   (i_clk_pixel),
    .i_reset (i_reset),
    .i_clr   (w_fe),
    .i_step  (w_line_end),
    .i_inc   (r_eff_h),
    .o_idx   (w_yy),
    .o_adv   (w_y_adv)
  );

  // Vertical sequencer, geometry latch, line base and registered read/video outputs.
  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_vstate      <= SYNC;
      r_eff_w       <= 10'd1;
      r_eff_h       <= 10'd1;
      r_line_base   <= '0;
      r_cur_x       <= 8'd0;
      r_cur_y       <= 8'd0;
      o_rd_en       <= 1'b0;
      o_rd_addr     <= '0;
      o_vid_active  <= 1'b0;
      o_overlay_x   <= 8'd0;
      o_overlay_y   <= 8'd0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= w_fe;
      o_vid_active  <= o_rd_en;
      o_overlay_x   <= r_cur_x;
      o_overlay_y   <= r_cur_y;

      if (w_fe) begin
        r_eff_w     <= w_req_w;
        r_eff_h     <= w_req_h;
        r_line_base <= '0;
      end else if (w_y_adv) begin
        // Stride add instead of yy*WIDTH; a saturated yy never gets here.
        r_line_base <= r_line_base + AW'(WIDTH);
      end

      if (w_in_hw) begin
        o_rd_en   <= 1'b1;
        o_rd_addr <= r_line_base + AW'(w_xx);
        r_cur_x   <= w_xx[7:0];
        r_cur_y   <= w_yy[7:0];
      end else begin
        o_rd_en   <= 1'b0;
      end

      case (r_vstate)
        SYNC: begin
          if (w_fe) r_vstate <= VACT;
        end
        VACT: begin
          if (w_line_end && (i_cy == 10'(V_ACTIVE - 1))) r_vstate <= VBLANK;
        end
        VBLANK: begin
          if (w_fe) r_vstate <= VACT;
        end
        default: begin
          r_vstate <= SYNC;
        end
      endcase
    end
  end

endmodule
